// File: rtl/screen_nav_fsm_if.sv
// Screen enum shared with the renderer, plus the navigation interface bundling
// the raw board keys, game_over and the menu outputs of screen_nav_fsm.
package common_enums;
   typedef enum logic [1:0] {
      TITLE_SCREEN  = 2'd0,
      PLAYER_SCREEN = 2'd1,
      SETUP_SCREEN  = 2'd2,
      CHESS_SCREEN  = 2'd3
   } screen_state_t;
endpackage

interface screen_nav_fsm_if;
   import common_enums::*;

   logic          key_sel_n;
   logic          key_back_n;
   logic          key_next_n;
   logic          key_prev_n;
   logic          game_over;
   screen_state_t screen_state;
   logic          screen_changed;
   logic [1:0]    num_players;
   logic          p1_white;

   modport master (
      output key_sel_n, key_back_n, key_next_n, key_prev_n, game_over,
      input  screen_state, screen_changed, num_players, p1_white
   );

   modport slave (
      input  key_sel_n, key_back_n, key_next_n, key_prev_n, game_over,
      output screen_state, screen_changed, num_players, p1_white
   );
endinterface

// File: rtl/screen_nav_fsm.sv
// Menu navigation controller: key synchronise/debounce/edge-detect feeding the
// TITLE->PLAYER->SETUP->CHESS screen FSM. Optional debouncer: SCREEN_NAV_DEBOUNCE_EN.
module screen_nav_fsm #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
   input logic         clk,
   input logic         rst_n,
   screen_nav_fsm_if.slave nav
);
   import common_enums::*;

   localparam int unsigned NKEY   = 4;
   localparam int unsigned K_SEL  = 0;
   localparam int unsigned K_BACK = 1;
   localparam int unsigned K_NEXT = 2;
   localparam int unsigned K_PREV = 3;

   localparam logic [1:0] ST_TITLE  = 2'd0;
   localparam logic [1:0] ST_PLAYER = 2'd1;
   localparam logic [1:0] ST_SETUP  = 2'd2;
   localparam logic [1:0] ST_CHESS  = 2'd3;

   logic [NKEY-1:0] key_raw;
   logic [NKEY-1:0] sync1_q, sync2_q, level, prev_q, press_q, arm_q;
   logic [1:0]      vld_q;

   assign key_raw = {nav.key_prev_n, nav.key_next_n, nav.key_back_n, nav.key_sel_n};

   // vld_q[1] marks when sync2_q holds a genuinely sampled key level
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q   <= '0;
         sync1_q <= '1;
         sync2_q <= '1;
      end else begin
         vld_q   <= {vld_q[0], 1'b1};
         sync1_q <= key_raw;
         sync2_q <= sync1_q;
      end
   end

`ifdef SCREEN_NAV_DEBOUNCE_EN
   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   for (genvar k = 0; k < NKEY; k++) begin : g_deb
      logic [CNT_W-1:0] cnt_q;
      logic             acc_q;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            cnt_q <= '0;
            acc_q <= 1'b1;
         end else if (sync2_q[k] == acc_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            cnt_q <= '0;
            acc_q <= sync2_q[k];
         end else begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end

      assign level[k] = acc_q;
   end
`else
   logic unused_debounce_cfg;
   assign unused_debounce_cfg = |32'(DEBOUNCE_CYCLES);
   assign level = sync2_q;
`endif

   // A key only arms after it has been seen released, so a key held through reset never fires
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_q  <= '1;
         press_q <= '0;
         arm_q   <= '0;
      end else begin
         prev_q  <= level;
         press_q <= arm_q & prev_q & ~level;
         arm_q   <= arm_q | ({NKEY{vld_q[1]}} & sync2_q & level);
      end
   end

   logic [1:0] state_q, state_d;
   logic [1:0] np_q, np_d;
   logic       white_q, white_d;
   logic       changed_q, changed_d;
   logic       ev_back, ev_sel, ev_next, ev_prev;

   // Next state: one winning press per cycle, priority back > sel > next > prev
   always_comb begin
      state_d = state_q;
      np_d    = np_q;
      white_d = white_q;
      ev_back = press_q[K_BACK];
      ev_sel  = press_q[K_SEL]  & ~press_q[K_BACK];
      ev_next = press_q[K_NEXT] & ~press_q[K_BACK] & ~press_q[K_SEL];
      ev_prev = press_q[K_PREV] & ~press_q[K_BACK] & ~press_q[K_SEL] & ~press_q[K_NEXT];
      case (state_q)
         ST_TITLE: begin
            if (ev_sel) state_d = ST_PLAYER;
         end
         ST_PLAYER: begin
            if (ev_back)                 state_d = ST_TITLE;
            else if (ev_sel)             state_d = ST_SETUP;
            else if (ev_next || ev_prev) np_d    = {np_q[0], np_q[1]};
         end
         ST_SETUP: begin
            if (ev_back)                 state_d = ST_PLAYER;
            else if (ev_sel)             state_d = ST_CHESS;
            else if (ev_next || ev_prev) white_d = ~white_q;
         end
         ST_CHESS: begin
            if (nav.game_over) state_d = ST_TITLE;
         end
         default: state_d = ST_TITLE;
      endcase
      changed_d = (state_d != state_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_TITLE;
         np_q      <= 2'd1;
         white_q   <= 1'b1;
         changed_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         np_q      <= np_d;
         white_q   <= white_d;
         changed_q <= changed_d;
      end
   end

   assign nav.screen_state   = screen_state_t'(state_q);
   assign nav.screen_changed = changed_q;
   assign nav.num_players    = np_q;
   assign nav.p1_white       = white_q;

endmodule

// File: tb/tb_screen_nav_fsm.sv
// Self-checking bench for screen_nav_fsm: table of key/game_over vectors with a
// queue of expected outputs, plus hand sequences for hold, reset and debounce cases.
module tb_screen_nav_fsm;
`ifdef SCREEN_NAV_DEBOUNCE_EN
   localparam int DB = 8;
`else
   localparam int DB = 0;
`endif
   localparam int LAT    = 4 + DB;
   localparam int SETTLE = DB + 6;
   localparam int NVEC   = 17;

   // keys bit: 0 sel, 1 back, 2 next, 3 prev (1 = pressed)
   typedef struct {
      logic [3:0] keys;
      logic       go;
      logic [1:0] st;
      logic [1:0] np;
      logic       white;
      logic       chg;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   int   n_tests = 0;
   int   n_fail  = 0;
   vec_t tbl [NVEC];
   vec_t expq [$];

   screen_nav_fsm_if nav ();

   screen_nav_fsm #(.DEBOUNCE_CYCLES(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .nav   (nav.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic drive_keys(input logic [3:0] k);
      nav.key_sel_n  = ~k[0];
      nav.key_back_n = ~k[1];
      nav.key_next_n = ~k[2];
      nav.key_prev_n = ~k[3];
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      rst_n = 1'b0;
      drive_keys(4'b0000);
      nav.game_over = 1'b0;
      #2;
      check({tag, " rst state"},   int'(nav.screen_state), 0);
      check({tag, " rst changed"}, int'(nav.screen_changed), 0);
      check({tag, " rst np"},      int'(nav.num_players), 1);
      check({tag, " rst white"},   int'(nav.p1_white), 1);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (SETTLE) @(posedge clk);
   endtask

   task automatic apply_vec(input vec_t v, input int idx);
      vec_t e;
      int   lat;
      @(negedge clk);
      if (v.go) nav.game_over = 1'b1;
      else      drive_keys(v.keys);
      expq.push_back(v);
      lat = v.go ? 1 : LAT;
      repeat (lat) @(posedge clk);
      #1;
      e = expq.pop_front();
      check($sformatf("vec%0d state", idx),   int'(nav.screen_state),   int'(e.st));
      check($sformatf("vec%0d np", idx),      int'(nav.num_players),    int'(e.np));
      check($sformatf("vec%0d white", idx),   int'(nav.p1_white),       int'(e.white));
      check($sformatf("vec%0d changed", idx), int'(nav.screen_changed), int'(e.chg));
      @(negedge clk);
      nav.game_over = 1'b0;
      drive_keys(4'b0000);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d pulse end", idx), int'(nav.screen_changed), 0);
      repeat (SETTLE) @(posedge clk);
   endtask

   initial begin
      int chg_cnt;
      rst_n = 1'b0;
      nav.game_over = 1'b0;
      drive_keys(4'b0000);

      //              keys     go    st     np     w     chg
      tbl[0]  = '{4'b0100, 1'b0, 2'd0, 2'd1, 1'b1, 1'b0}; // next ignored in TITLE
      tbl[1]  = '{4'b0001, 1'b0, 2'd1, 2'd1, 1'b1, 1'b1}; // sel -> PLAYER
      tbl[2]  = '{4'b0100, 1'b0, 2'd1, 2'd2, 1'b1, 1'b0}; // next 1->2
      tbl[3]  = '{4'b0100, 1'b0, 2'd1, 2'd1, 1'b1, 1'b0}; // next 2->1
      tbl[4]  = '{4'b0100, 1'b0, 2'd1, 2'd2, 1'b1, 1'b0}; // next 1->2
      tbl[5]  = '{4'b0001, 1'b0, 2'd2, 2'd2, 1'b1, 1'b1}; // sel -> SETUP
      tbl[6]  = '{4'b1000, 1'b0, 2'd2, 2'd2, 1'b0, 1'b0}; // prev -> black
      tbl[7]  = '{4'b0010, 1'b0, 2'd1, 2'd2, 1'b0, 1'b1}; // back -> PLAYER, np kept
      tbl[8]  = '{4'b0001, 1'b0, 2'd2, 2'd2, 1'b0, 1'b1}; // sel -> SETUP
      tbl[9]  = '{4'b0011, 1'b0, 2'd1, 2'd2, 1'b0, 1'b1}; // sel+back: back wins
      tbl[10] = '{4'b0001, 1'b0, 2'd2, 2'd2, 1'b0, 1'b1}; // sel -> SETUP
      tbl[11] = '{4'b1100, 1'b0, 2'd2, 2'd2, 1'b1, 1'b0}; // next+prev: single toggle
      tbl[12] = '{4'b0001, 1'b0, 2'd3, 2'd2, 1'b1, 1'b1}; // sel -> CHESS
      tbl[13] = '{4'b1111, 1'b0, 2'd3, 2'd2, 1'b1, 1'b0}; // all keys ignored in CHESS
      tbl[14] = '{4'b0000, 1'b1, 2'd0, 2'd2, 1'b1, 1'b1}; // game_over -> TITLE
      tbl[15] = '{4'b0000, 1'b1, 2'd0, 2'd2, 1'b1, 1'b0}; // game_over ignored in TITLE
      tbl[16] = '{4'b0010, 1'b0, 2'd0, 2'd2, 1'b1, 1'b0}; // back ignored in TITLE

      do_reset("init");

      // Held sel: single transition, exact latency, no repeat
      @(negedge clk);
      drive_keys(4'b0001);
      repeat (LAT - 1) @(posedge clk);
      #1;
      check("hold early state", int'(nav.screen_state), 0);
      @(posedge clk);
      #1;
      check("hold state",   int'(nav.screen_state), 1);
      check("hold changed", int'(nav.screen_changed), 1);
      chg_cnt = 0;
      repeat (100) begin
         @(posedge clk);
         #1;
         if (nav.screen_changed) chg_cnt++;
      end
      check("hold repeats", chg_cnt, 0);
      check("hold final state", int'(nav.screen_state), 1);
      @(negedge clk);
      drive_keys(4'b0000);
      repeat (SETTLE) @(posedge clk);

      do_reset("tbl");
      for (int i = 0; i < NVEC; i++) apply_vec(tbl[i], i);
      check("queue drained", expq.size(), 0);

      // Key held across reset release gives no press
      @(negedge clk);
      rst_n = 1'b0;
      nav.key_sel_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      chg_cnt = 0;
      repeat (LAT + 20) begin
         @(posedge clk);
         #1;
         if (nav.screen_changed) chg_cnt++;
      end
      check("held rst changes", chg_cnt, 0);
      check("held rst state", int'(nav.screen_state), 0);
      @(negedge clk);
      nav.key_sel_n = 1'b1;
      repeat (SETTLE) @(posedge clk);
      apply_vec('{4'b0001, 1'b0, 2'd1, 2'd1, 1'b1, 1'b1}, 100);

`ifdef SCREEN_NAV_DEBOUNCE_EN
      do_reset("db");
      @(negedge clk);
      nav.key_sel_n = 1'b0;
      repeat (5) @(negedge clk);
      nav.key_sel_n = 1'b1;
      chg_cnt = 0;
      repeat (30) begin
         @(posedge clk);
         #1;
         if (nav.screen_changed) chg_cnt++;
      end
      check("db glitch changes", chg_cnt, 0);
      check("db glitch state", int'(nav.screen_state), 0);

      @(negedge clk);
      nav.key_sel_n = 1'b0;
      repeat (LAT - 1) @(posedge clk);
      #1;
      check("db early state", int'(nav.screen_state), 0);
      @(posedge clk);
      #1;
      check("db state",   int'(nav.screen_state), 1);
      check("db changed", int'(nav.screen_changed), 1);
      @(negedge clk);
      nav.key_sel_n = 1'b1;
      chg_cnt = 0;
      repeat (30) begin
         @(posedge clk);
         #1;
         if (nav.screen_changed) chg_cnt++;
      end
      check("db single press", chg_cnt, 0);

      @(negedge clk);
      nav.key_next_n = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("db midrst state", int'(nav.screen_state), 0);
      check("db midrst np", int'(nav.num_players), 1);
      @(negedge clk);
      rst_n = 1'b1;
      nav.key_next_n = 1'b1;
      repeat (30) @(posedge clk);
      #1;
      check("db midrst after", int'(nav.num_players), 1);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
